ace_ccu_snoop_conflict_mgr: RTL and testbench
=============================================

ACE_CCU_SNOOP_CONFLICT_MGR -- requirements
Module: ace_ccu_snoop_conflict_mgr

Interface
REQ-001 SHALL have parameter NumEntries, default 4, meaning max in-flight snoops tracked; legal range 2..16.
REQ-002 SHALL have parameter CmAddrWidth, default 8, meaning width of the compared address slice.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cm_valid_i  input  1  snoop request presented at the interconnect arbiter output.
REQ-006 SHALL have port cm_ready_i  input  1  downstream snoop fork ready.
REQ-007 SHALL have port cm_addr_i  input  CmAddrWidth  address slice of the presented snoop.
REQ-008 SHALL have port cm_stall_o  output  1  block the presented snoop this cycle.
REQ-009 SHALL have port cm_done_i  input  1  one-cycle pulse per completed snoop response, in issue order.
REQ-010 SHALL have port usage_o  output  $clog2(NumEntries+1)  current in-flight count.
REQ-011 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-012 SHALL hold a circular table of NumEntries {valid, addr}, write pointer, read pointer, count.
REQ-013 SHALL define accept = cm_valid_i && cm_ready_i && !cm_stall_o; on accept, write cm_addr_i at write pointer, set valid, advance write pointer.
REQ-014 SHALL, on cm_done_i with count>0, clear the entry at read pointer and advance read pointer.
REQ-015 SHALL wrap both pointers from NumEntries-1 to 0, with no power-of-two requirement.
REQ-016 SHALL drive cm_stall_o combinationally = cm_valid_i && (hit || full); hit = any valid entry's addr equals cm_addr_i; full = count==NumEntries.
REQ-017 SHALL NOT make cm_stall_o depend on cm_ready_i, so no combinational loop exists with ready paths gated by stall.
REQ-018 SHALL drive cm_stall_o low whenever cm_valid_i is low.
REQ-019 SHALL, on simultaneous accept and done, perform both operations and leave count unchanged.
REQ-020 SHALL, on cm_done_i with count==0, ignore the pop, keep pointers unchanged, and set err_o.
REQ-021 SHALL give usage_o zero-latency registered count; allocation and release take effect one cycle after the handshake edge.
REQ-022 SHALL allow a stalled snoop to proceed in the first cycle after the blocking entry is released (base latency, without REQ-027).

Reset
REQ-023 SHALL, on rst_ni low, asynchronously clear all valid bits, both pointers, count, and err_o.
REQ-024 SHALL have these reset output values: cm_stall_o = 0 while cm_valid_i = 0; usage_o = 0; err_o = 0.
REQ-025 SHALL discard in-flight entries on reset mid-operation; done pulses after reset with empty table set err_o.
REQ-026 SHALL keep err_o set until reset.

Configuration
REQ-027 SHALL support macro ACE_CCU_CM_RELEASE_FWD_EN; when defined, the head entry is excluded from hit, and full is evaluated as count==NumEntries && !cm_done_i when cm_done_i is asserted in the same cycle, so a blocked snoop proceeds in the release cycle.
REQ-028 SHALL, without ACE_CCU_CM_RELEASE_FWD_EN, use registered table state only, so a release unblocks the following cycle.

Structure
REQ-029 SHALL place cm entry typedef {valid, addr} and default NumEntries constant in shared package ace_ccu_cm_pkg.
REQ-030 SHALL implement the table, pointers, and parallel compare in one sub-module ace_ccu_cm_table; the top holds handshake, stall, and error logic.

Verification
REQ-031 SHALL verify basic conflict: accept addr 0x12; next cycle present 0x12 -> stall=1 until done; without FWD, stall=0 the cycle after done.
REQ-032 SHALL verify no conflict: accept 0x12, present 0x34 -> stall=0, accepted, usage_o=2.
REQ-033 SHALL verify full: accept 0x01..0x04 (NumEntries=4), present 0x05 -> stall=1; with FWD and done same cycle -> stall=0, usage_o stays 4.
REQ-034 SHALL verify wrap-around: 10 alternating accept/done of distinct addrs -> pointers wrap, usage_o never exceeds 1, no false hit.
REQ-035 SHALL verify underflow: done with usage_o=0 -> err_o=1 held; reset -> err_o=0, usage_o=0.
REQ-036 SHALL verify ready independence: cm_ready_i=0 with a conflicting addr -> stall=1, no allocation; cm_ready_i=0 with no conflict -> stall=0, usage_o unchanged.

Source files
------------

// File: rtl/ace_ccu_cm_pkg.sv
// Shared types and defaults for the ACE CCU snoop conflict manager.
// The table entry holds a valid bit and an address slice zero-extended to CmAddrWidthMax.
package ace_ccu_cm_pkg;

  localparam int unsigned CmNumEntriesDefault = 4;
  localparam int unsigned CmAddrWidthMax      = 32;

  typedef struct packed {
    logic                      valid;
    logic [CmAddrWidthMax-1:0] addr;
  } cm_entry_t;

  // Circular increment that wraps at n, so n need not be a power of two.
  function automatic int unsigned cm_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ace_ccu_cm_table.sv
// In-flight snoop table: circular {valid, addr} store, pointers, count, and a parallel address compare.
// Push and pop update state on the next rising edge; hit_o is purely combinational.
module ace_ccu_cm_table
  import ace_ccu_cm_pkg::*;
#(
  parameter int unsigned NumEntries  = CmNumEntriesDefault,
  parameter int unsigned CmAddrWidth = 8,
  localparam int unsigned PtrWidth   = $clog2(NumEntries),
  localparam int unsigned CntWidth   = $clog2(NumEntries + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [CmAddrWidth-1:0] push_addr_i,
  input  logic                   pop_i,
  input  logic [CmAddrWidth-1:0] cmp_addr_i,
  input  logic                   excl_head_i,
  output logic                   hit_o,
  output logic [CntWidth-1:0]    count_o
);

  cm_entry_t             table_q [NumEntries];
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CntWidth-1:0]   count_q;
  logic [CmAddrWidthMax-1:0] push_addr_ext;
  logic [CmAddrWidthMax-1:0] cmp_addr_ext;

  assign push_addr_ext = CmAddrWidthMax'(push_addr_i);
  assign cmp_addr_ext  = CmAddrWidthMax'(cmp_addr_i);

  // Push is applied after pop so a full-table release-and-refill of one slot keeps the new entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumEntries; i++) begin
        table_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_i) begin
        table_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q <= PtrWidth'(cm_wrap_inc(32'(rd_ptr_q), NumEntries));
      end
      if (push_i) begin
        table_q[wr_ptr_q].valid <= 1'b1;
        table_q[wr_ptr_q].addr  <= push_addr_ext;
        wr_ptr_q <= PtrWidth'(cm_wrap_inc(32'(wr_ptr_q), NumEntries));
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (table_q[i].valid && (table_q[i].addr == cmp_addr_ext) &&
          !(excl_head_i && (PtrWidth'(i) == rd_ptr_q))) begin
        hit_o = 1'b1;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ace_ccu_snoop_conflict_mgr.sv
// Stalls a presented snoop while an in-flight snoop to the same address slice exists or the tracker is full.
// Optional ACE_CCU_CM_RELEASE_FWD_EN lets a release in the current cycle unblock the presented snoop immediately.
module ace_ccu_snoop_conflict_mgr
  import ace_ccu_cm_pkg::*;
#(
  parameter int unsigned NumEntries  = CmNumEntriesDefault,
  parameter int unsigned CmAddrWidth = 8,
  localparam int unsigned CntWidth   = $clog2(NumEntries + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cm_valid_i,
  input  logic                   cm_ready_i,
  input  logic [CmAddrWidth-1:0] cm_addr_i,
  output logic                   cm_stall_o,
  input  logic                   cm_done_i,
  output logic [CntWidth-1:0]    usage_o,
  output logic                   err_o
);

  logic [CntWidth-1:0] count;
  logic                hit;
  logic                full;
  logic                excl_head;
  logic                pop;
  logic                underflow;
  logic                accept;
  logic                err_q;

  assign pop       = cm_done_i && (count != '0);
  assign underflow = cm_done_i && (count == '0);

`ifdef ACE_CCU_CM_RELEASE_FWD_EN
  assign excl_head = pop;
  assign full      = (count == CntWidth'(NumEntries)) && !pop;
`else
  assign excl_head = 1'b0;
  assign full      = (count == CntWidth'(NumEntries));
`endif

  // Stall never looks at cm_ready_i, so ready paths gated by stall cannot form a loop.
  assign cm_stall_o = cm_valid_i && (hit || full);
  assign accept     = cm_valid_i && cm_ready_i && !cm_stall_o;

  ace_ccu_cm_table #(
    .NumEntries  (NumEntries),
    .CmAddrWidth (CmAddrWidth)
  ) u_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_addr_i (cm_addr_i),
    .pop_i       (pop),
    .cmp_addr_i  (cm_addr_i),
    .excl_head_i (excl_head),
    .hit_o       (hit),
    .count_o     (count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  assign usage_o = count;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ace_ccu_snoop_conflict_mgr.sv
// Vector-table bench for the snoop conflict manager; expectations assume NumEntries=4, CmAddrWidth=8.
module tb_ace_ccu_snoop_conflict_mgr;

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] a;
    logic       d;
    logic       exp_stall;
    logic [2:0] exp_usage;
    logic       exp_err;
  } vec_t;

  logic       clk_i;
  logic       rst_ni;
  logic       cm_valid_i;
  logic       cm_ready_i;
  logic [7:0] cm_addr_i;
  logic       cm_stall_o;
  logic       cm_done_i;
  logic [2:0] usage_o;
  logic       err_o;

  int   tests;
  int   fails;
  int   step;
  vec_t vecs[$];
  vec_t exp_q[$];

  ace_ccu_snoop_conflict_mgr #(
    .NumEntries  (4),
    .CmAddrWidth (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cm_valid_i (cm_valid_i),
    .cm_ready_i (cm_ready_i),
    .cm_addr_i  (cm_addr_i),
    .cm_stall_o (cm_stall_o),
    .cm_done_i  (cm_done_i),
    .usage_o    (usage_o),
    .err_o      (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic r, input logic [7:0] a, input logic d,
                     input logic s, input logic [2:0] u, input logic e);
    vec_t t;
    t.v = v; t.r = r; t.a = a; t.d = d;
    t.exp_stall = s; t.exp_usage = u; t.exp_err = e;
    vecs.push_back(t);
  endtask

  // Drive one cycle, check stall before the edge and state after it.
  task automatic apply(input vec_t t);
    vec_t e;
    @(negedge clk_i);
    cm_valid_i = t.v;
    cm_ready_i = t.r;
    cm_addr_i  = t.a;
    cm_done_i  = t.d;
    exp_q.push_back(t);
    #1;
    check("stall", 32'(cm_stall_o), 32'(exp_q[0].exp_stall));
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check("usage", 32'(usage_o), 32'(e.exp_usage));
    check("err", 32'(err_o), 32'(e.exp_err));
    step++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni     = 1'b0;
    cm_valid_i = 1'b0;
    cm_ready_i = 1'b0;
    cm_done_i  = 1'b0;
    #1;
    check("rst_usage", 32'(usage_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(cm_stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    vec_t h;
    tests = 0; fails = 0; step = 0;
    rst_ni = 1'b0; cm_valid_i = 1'b0; cm_ready_i = 1'b0; cm_addr_i = 8'h00; cm_done_i = 1'b0;

    // v  r  addr   d  stall usage err
    add(1, 1, 8'h12, 0, 0, 3'd1, 0);
    add(1, 1, 8'h12, 0, 1, 3'd1, 0);
`ifdef ACE_CCU_CM_RELEASE_FWD_EN
    add(1, 1, 8'h12, 1, 0, 3'd1, 0);
    add(1, 1, 8'h12, 0, 1, 3'd1, 0);
`else
    add(1, 1, 8'h12, 1, 1, 3'd0, 0);
    add(1, 1, 8'h12, 0, 0, 3'd1, 0);
`endif
    add(1, 1, 8'h34, 0, 0, 3'd2, 0);
    add(0, 1, 8'h12, 0, 0, 3'd2, 0);
    add(1, 0, 8'h12, 0, 1, 3'd2, 0);
    add(1, 0, 8'h56, 0, 0, 3'd2, 0);
    add(0, 0, 8'h00, 1, 0, 3'd1, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0);
    add(1, 1, 8'h01, 0, 0, 3'd1, 0);
    add(1, 1, 8'h02, 0, 0, 3'd2, 0);
    add(1, 1, 8'h03, 0, 0, 3'd3, 0);
    add(1, 1, 8'h04, 0, 0, 3'd4, 0);
    add(1, 1, 8'h05, 0, 1, 3'd4, 0);
`ifdef ACE_CCU_CM_RELEASE_FWD_EN
    add(1, 1, 8'h05, 1, 0, 3'd4, 0);
    add(1, 1, 8'h05, 0, 1, 3'd4, 0);
`else
    add(1, 1, 8'h05, 1, 1, 3'd3, 0);
    add(1, 1, 8'h05, 0, 0, 3'd4, 0);
`endif
    add(0, 0, 8'h00, 1, 0, 3'd3, 0);
    add(0, 0, 8'h00, 1, 0, 3'd2, 0);
    add(0, 0, 8'h00, 1, 0, 3'd1, 0);
    add(0, 0, 8'h00, 1, 0, 3'd0, 0);
    // Pointers lap the 4-entry ring; reused addresses expose any stale valid bit.
    for (int k = 0; k < 10; k++) begin
      add(1, 1, 8'h80 + 8'(k % 3), 0, 0, 3'd1, 0);
      add(0, 0, 8'h00, 1, 0, 3'd0, 0);
    end
    add(0, 0, 8'h00, 1, 0, 3'd0, 1);
    add(0, 0, 8'h00, 0, 0, 3'd0, 1);
    add(1, 1, 8'h80, 0, 0, 3'd1, 1);

    #1;
    check("init_usage", 32'(usage_o), 32'd0);
    check("init_err", 32'(err_o), 32'd0);
    check("init_stall", 32'(cm_stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Reset clears sticky error and the in-flight entry.
    do_reset();

    // Reset mid-operation discards the entry; a later done is an underflow.
    h = '{v:1, r:1, a:8'h11, d:0, exp_stall:0, exp_usage:3'd1, exp_err:0};
    apply(h);
    do_reset();
    h = '{v:0, r:0, a:8'h00, d:1, exp_stall:0, exp_usage:3'd0, exp_err:1};
    apply(h);
    h = '{v:1, r:1, a:8'h11, d:0, exp_stall:0, exp_usage:3'd1, exp_err:1};
    apply(h);

    @(negedge clk_i);
    cm_valid_i = 1'b0;
    cm_done_i  = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
